plugboard: RTL and testbench

PLUGBOARD -- requirements
Module: plugboard

---
 rtl/plugboard.sv | 139 +++++++++++++
 tb/tb_plugboard.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plugboard.sv
// plugboard
//   Buffers incoming ASCII characters in a small FIFO and substitutes each
//   letter through a 26-entry swap table. Characters go to the rotor stage
//   one at a time: a one-cycle dout_valid strobe, then dout is held until
//   rotor_done comes back.
//
//   Ports
//     clk, reset_n      clock, asynchronous active-low reset
//     set, pair_in      swap table load (letter i at pair_in[200-8*i +: 8])
//     din_valid, din    upstream character, taken when din_ready is high
//     din_ready         a push is accepted on this edge
//     rotor_done        rotor has consumed the current character
//     dout, dout_valid  mapped character and its strobe
//     busy              FSM active or characters buffered
//     err               unmapped character, pulses with dout_valid
//
//   Build option
//     PLUGBOARD_LOWERCASE_EN  fold lowercase letters to uppercase before
//                             mapping instead of flagging them as errors
//
//   state | meaning
//   IDLE  | waiting for a buffered character
//   ISSUE | dout_valid strobe cycle
//   WAIT  | dout held until rotor_done
module plugboard #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         set,
  input  logic [207:0] pair_in,
  input  logic         din_valid,
  input  logic [7:0]   din,
  output logic         din_ready,
  input  logic         rotor_done,
  output logic [7:0]   dout,
  output logic         dout_valid,
  output logic         busy,
  output logic         err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    swap_tab [26];

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic [7:0]    folded;
  logic [4:0]    letter_idx;
  logic [7:0]    mapped;
  logic          map_err;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = (state == IDLE) && !fifo_empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign din_ready  = !fifo_full || pop;
  assign push       = din_valid && din_ready;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign head       = fifo_mem[rd_ptr];

  always_comb begin
    folded = head;
`ifdef PLUGBOARD_LOWERCASE_EN
    if (head >= 8'h61 && head <= 8'h7A) folded = head - 8'h20;
`endif
    // 'A'..'Z' have low five bits 1..26
    letter_idx = folded[4:0] - 5'd1;
    if (folded >= 8'h41 && folded <= 8'h5A) begin
      mapped  = swap_tab[letter_idx];
      map_err = 1'b0;
    end else begin
      mapped  = head;
      map_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < 26; i++) swap_tab[i] <= 8'h41 + 8'(i);
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      if (set && state == IDLE && fifo_empty) begin
        for (int i = 0; i < 26; i++) swap_tab[i] <= pair_in[200-8*i +: 8];
      end

      case (state)
        IDLE: begin
          if (pop) begin
            dout       <= mapped;
            dout_valid <= 1'b1;
            err        <= map_err;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          dout_valid <= 1'b0;
          err        <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (rotor_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plugboard.sv
`timescale 1ns/1ps
module tb_plugboard;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         set;
  logic [207:0] pair_in;
  logic         din_valid;
  logic [7:0]   din;
  logic         din_ready;
  logic         rotor_done;
  logic [7:0]   dout;
  logic         dout_valid;
  logic         busy;
  logic         err;

  int vectors = 0;
  int miscompares = 0;

  // reference: swap table contents and queue of expected {err, dout}
  logic [7:0] mtab [26];
  logic [8:0] exp_q [$];

  plugboard #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .set(set), .pair_in(pair_in),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .rotor_done(rotor_done), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] model_map(input logic [7:0] c);
    int code;
    code = int'(c);
`ifdef PLUGBOARD_LOWERCASE_EN
    if (code >= 'h61 && code <= 'h7A) code = code - 'h20;
`endif
    if (code >= 'h41 && code <= 'h5A) return {1'b0, mtab[code - 'h41]};
    return {1'b1, c};
  endfunction

  function automatic logic [7:0] rand_char();
    int k;
    k = int'($urandom_range(0, 9));
    if (k < 6) return 8'($urandom_range(8'h41, 8'h5A));
    if (k < 8) return 8'($urandom_range(8'h61, 8'h7A));
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic identity_tab();
    for (int i = 0; i < 26; i++) mtab[i] = 8'h41 + 8'(i);
  endtask

  task automatic load_tab();
    for (int i = 0; i < 26; i++) pair_in[200-8*i +: 8] = mtab[i];
    set = 1'b1;
    step();
    set = 1'b0;
  endtask

  task automatic push_char(input logic [7:0] c);
    din_valid = 1'b1;
    din = c;
    step();
    din_valid = 1'b0;
  endtask

  task automatic finish_rotor(input int delay);
    repeat (delay) step();
    rotor_done = 1'b1;
    step();
    rotor_done = 1'b0;
  endtask

  // looks at the current sample first, then steps; to=1 when no strobe seen
  task automatic wait_out(output logic [7:0] d, output logic e, output bit to);
    to = 1'b1; d = 8'h00; e = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (dout_valid === 1'b1) begin
        d = dout; e = err; to = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; set = 1'b0; pair_in = '0; din_valid = 1'b0; din = 8'h00; rotor_done = 1'b0;
    identity_tab();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h expected 00", dout); end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (din_ready !== 1'b1) begin miscompares++; $display("FAIL reset_din_ready: got %b expected 1", din_ready); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    logic [8:0] e;
    e = model_map(8'h43);
    din_valid = 1'b1; din = 8'h43;
    step();
    din_valid = 1'b0;
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early: got %b expected 0", dout_valid); end
    step();
    vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("FAIL latency_valid: got %b expected 1", dout_valid); end
    vectors++; if ({err, dout} !== e) begin miscompares++; $display("FAIL latency_data: got %h expected %h", {err, dout}, e); end
    step();
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL latency_strobe_len: got %b expected 0", dout_valid); end
    vectors++; if (dout !== e[7:0]) begin miscompares++; $display("FAIL latency_hold: got %h expected %h", dout, e[7:0]); end
    finish_rotor(1);
  endtask

  task automatic test_swap();
    logic [7:0] d; logic e; bit to;
    identity_tab();
    mtab[0] = 8'h5A; mtab[25] = 8'h41;
    load_tab();
    push_char(8'h41);
    push_char(8'h5A);
    wait_out(d, e, to);
    vectors++; if (to || {e, d} !== model_map(8'h41)) begin miscompares++; $display("FAIL swap_first: got %h timeout %0d expected %h", {e, d}, to, model_map(8'h41)); end
    finish_rotor(3);
    wait_out(d, e, to);
    vectors++; if (to || {e, d} !== model_map(8'h5A)) begin miscompares++; $display("FAIL swap_second: got %h timeout %0d expected %h", {e, d}, to, model_map(8'h5A)); end
    finish_rotor(3);
    step();
    identity_tab();
    load_tab();
  endtask

  task automatic test_full();
    logic [7:0] c [6]; logic [7:0] d; logic e; bit to; logic [8:0] x; int base; int extra;
    base = int'($urandom_range(0, 25));
    for (int i = 0; i < 6; i++) c[i] = 8'(65 + (base + 5 * i) % 26);
    rotor_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din_valid = 1'b1; din = c[i];
      vectors++; if (din_ready !== (i < 5)) begin miscompares++; $display("FAIL full_ready_%0d: got %b expected %b", i, din_ready, (i < 5)); end
      if (din_ready) exp_q.push_back(model_map(c[i]));
      step();
    end
    din_valid = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL full_busy: got %b expected 1", busy); end
    x = exp_q.pop_front();
    vectors++; if (dout_valid !== 1'b0 || dout !== x[7:0]) begin miscompares++; $display("FAIL full_wait_hold: got %h valid %b expected %h", dout, dout_valid, x[7:0]); end
    finish_rotor(1);
    for (int k = 0; k < 4; k++) begin
      wait_out(d, e, to);
      x = exp_q.pop_front();
      vectors++; if (to || {e, d} !== x) begin miscompares++; $display("FAIL full_drain_%0d: got %h timeout %0d expected %h", k, {e, d}, to, x); end
      finish_rotor(1);
    end
    extra = 0;
    for (int n = 0; n < 10; n++) begin
      if (dout_valid === 1'b1) extra++;
      step();
    end
    vectors++; if (extra != 0) begin miscompares++; $display("FAIL full_dropped: got %0d extra strobes expected 0", extra); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] d; logic e; bit to; logic [8:0] x; logic [7:0] c;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      c = 8'($urandom_range(8'h41, 8'h5A));
      exp_q.push_back(model_map(c));
      push_char(c);
    end
    void'(exp_q.pop_front());
    rotor_done = 1'b1;
    step();
    rotor_done = 1'b0;
    vectors++; if (din_ready !== 1'b1) begin miscompares++; $display("FAIL pushpop_ready: got %b expected 1", din_ready); end
    c = 8'h2A;
    exp_q.push_back(model_map(c));
    din_valid = 1'b1; din = c;
    step();
    din_valid = 1'b0;
    x = exp_q.pop_front();
    vectors++; if (dout_valid !== 1'b1 || {err, dout} !== x) begin miscompares++; $display("FAIL pushpop_pop: got %h valid %b expected %h", {err, dout}, dout_valid, x); end
    vectors++; if (din_ready !== 1'b0) begin miscompares++; $display("FAIL pushpop_still_full: got %b expected 0", din_ready); end
    finish_rotor(1);
    for (int k = 0; k < 4; k++) begin
      wait_out(d, e, to);
      x = exp_q.pop_front();
      vectors++; if (to || {e, d} !== x) begin miscompares++; $display("FAIL pushpop_drain_%0d: got %h timeout %0d expected %h", k, {e, d}, to, x); end
      finish_rotor(1);
    end
  endtask

  task automatic test_err();
    logic [7:0] d; logic e; bit to;
    push_char(8'h21);
    wait_out(d, e, to);
    vectors++; if (to || {e, d} !== 9'h121) begin miscompares++; $display("FAIL err_char: got %h timeout %0d expected 121", {e, d}, to); end
    step();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_pulse_len: got %b expected 0", err); end
    finish_rotor(1);
  endtask

  task automatic test_lowercase();
    logic [7:0] d; logic e; bit to; logic [8:0] x;
    x = model_map(8'h62);
    push_char(8'h62);
    wait_out(d, e, to);
    vectors++; if (to || {e, d} !== x) begin miscompares++; $display("FAIL lowercase_b: got %h timeout %0d expected %h", {e, d}, to, x); end
    finish_rotor(1);
  endtask

  task automatic test_set_ignored();
    logic [7:0] d; logic e; bit to;
    push_char(8'h41);
    push_char(8'h42);
    wait_out(d, e, to);
    vectors++; if (to || {e, d} !== model_map(8'h41)) begin miscompares++; $display("FAIL setign_first: got %h timeout %0d expected %h", {e, d}, to, model_map(8'h41)); end
    for (int i = 0; i < 26; i++) pair_in[200-8*i +: 8] = 8'h5A - 8'(i);
    set = 1'b1;
    step();
    set = 1'b0;
    finish_rotor(1);
    wait_out(d, e, to);
    vectors++; if (to || {e, d} !== model_map(8'h42)) begin miscompares++; $display("FAIL setign_second: got %h timeout %0d expected %h", {e, d}, to, model_map(8'h42)); end
    finish_rotor(1);
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    for (int i = 0; i < 4; i++) push_char(8'($urandom_range(8'h41, 8'h5A)));
    vectors++; if (busy !== 1'b1 || din_ready !== 1'b1) begin miscompares++; $display("FAIL rstwait_pre: got busy %b ready %b expected 1 1", busy, din_ready); end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstwait_busy: got %b expected 0", busy); end
    vectors++; if (din_ready !== 1'b1) begin miscompares++; $display("FAIL rstwait_ready: got %b expected 1", din_ready); end
    vectors++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin miscompares++; $display("FAIL rstwait_out: got %h valid %b expected 00 0", dout, dout_valid); end
    identity_tab();
    exp_q.delete();
    step();
    reset_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      if (dout_valid === 1'b1) seen++;
      step();
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL rstwait_ghost: got %0d strobes expected 0", seen); end
  endtask

  task automatic test_random();
    logic [7:0] t; int j; bit awaiting; bit ignore_done; bit have_last; logic [7:0] last_dout; logic [8:0] x;
    for (int i = 25; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = mtab[i]; mtab[i] = mtab[j]; mtab[j] = t;
    end
    load_tab();
    exp_q.delete();
    awaiting = 1'b0; ignore_done = 1'b0; have_last = 1'b0; last_dout = 8'h00;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (dout_valid === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL rand_unexpected: got %h expected no output", {err, dout});
        end else begin
          x = exp_q.pop_front();
          if ({err, dout} !== x) begin miscompares++; $display("FAIL rand_data: got %h expected %h", {err, dout}, x); end
        end
        vectors++; if (awaiting) begin miscompares++; $display("FAIL rand_handshake: got strobe before rotor_done expected none"); end
        awaiting = 1'b1; ignore_done = 1'b1; last_dout = dout; have_last = 1'b1;
      end else begin
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rand_err_alone: got %b expected 0", err); end
        if (have_last) begin
          vectors++; if (dout !== last_dout) begin miscompares++; $display("FAIL rand_hold: got %h expected %h", dout, last_dout); end
        end
      end
      if (cyc < 350) begin
        din_valid = 1'($urandom_range(0, 1));
        din = rand_char();
        rotor_done = ($urandom_range(0, 3) == 0);
      end else begin
        din_valid = 1'b0;
        rotor_done = 1'b1;
      end
      if (din_valid && din_ready) exp_q.push_back(model_map(din));
      if (rotor_done && !ignore_done) awaiting = 1'b0;
      ignore_done = 1'b0;
      step();
    end
    din_valid = 1'b0; rotor_done = 1'b0;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand_leftover: got %0d pending expected 0", exp_q.size()); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rand_end_busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_swap();
    test_full();
    test_push_pop_full();
    test_err();
    test_lowercase();
    test_set_ignored();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
